// File: rtl/csla_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : csla_pkg                                                   |
// | Description : Shared constants and helpers for the pipelined             |
// |               carry-select adder (csla_pipe_adder, csla_seg).            |
// |               c_DEF_* are default width / segment / stage counts.        |
// |               csla_sps() gives the number of segments per stage.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package csla_pkg;

   localparam int c_DEF_WIDTH  = 16;
   localparam int c_DEF_BLK    = 4;
   localparam int c_DEF_STAGES = 2;

   // Segments resolved per pipeline stage.
   function automatic int csla_sps(input int width, input int blk, input int stages);
      return width / blk / stages;
   endfunction

endpackage
`default_nettype wire

// File: rtl/csla_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csla_seg                                                   |
// | Description : One BLK-bit carry-select segment. Two ripple adders form   |
// |               the sum for carry-in 0 and carry-in 1; the real incoming   |
// |               carry selects between them.                                |
// | Ports       : i_a, i_b  [BLK]  operand slices                            |
// |               i_ci      [1]    incoming carry (select)                   |
// |               o_s       [BLK]  selected sum slice                        |
// |               o_co      [1]    selected carry out                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csla_seg
   import csla_pkg::*;
#(
   parameter int BLK = c_DEF_BLK
) (
   input  logic [BLK-1:0] i_a,
   input  logic [BLK-1:0] i_b,
   input  logic           i_ci,
   output logic [BLK-1:0] o_s,
   output logic           o_co
);

   logic [BLK:0] w_sum0;
   logic [BLK:0] w_sum1;
   logic         w_c0;
   logic         w_c1;

   // Both ripple chains are evaluated in parallel, independent of i_ci.
   always_comb begin
      w_sum0 = '0;
      w_sum1 = '0;
      w_c0   = 1'b0;
      w_c1   = 1'b1;
      for (int i = 0; i < BLK; i++) begin
         w_sum0[i] = i_a[i] ^ i_b[i] ^ w_c0;
         w_c0      = (i_a[i] & i_b[i]) | (w_c0 & (i_a[i] ^ i_b[i]));
         w_sum1[i] = i_a[i] ^ i_b[i] ^ w_c1;
         w_c1      = (i_a[i] & i_b[i]) | (w_c1 & (i_a[i] ^ i_b[i]));
      end
      w_sum0[BLK] = w_c0;
      w_sum1[BLK] = w_c1;
   end

   assign {o_co, o_s} = i_ci ? w_sum1 : w_sum0;

endmodule
`default_nettype wire

// File: rtl/csla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csla_pipe_adder                                            |
// | Description : Pipelined carry-select adder, S = (A+B+Cin) mod 2^WIDTH,   |
// |               with valid/ready handshakes on input and output.           |
// |               Stage j resolves segments [j*SPS, (j+1)*SPS); the carry    |
// |               between stages is registered, so one add issues per cycle. |
// |               Latency is STAGES cycles; outputs come straight from the   |
// |               last stage register.                                       |
// | Ports       : clk, rst_n (async, active low)                             |
// |               i_in_valid / o_in_ready   input handshake                  |
// |               i_a, i_b [WIDTH], i_cin   operands and carry in            |
// |               o_out_valid / i_out_ready output handshake                 |
// |               o_s [WIDTH], o_cout       sum and carry out                |
// |               o_v                       signed overflow (CSLA_OVF_EN)    |
// | Config      : define CSLA_OVF_EN to add the o_v port and its register.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csla_pipe_adder
   import csla_pkg::*;
#(
   parameter int WIDTH  = c_DEF_WIDTH,
   parameter int BLK    = c_DEF_BLK,
   parameter int STAGES = c_DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_cout
`ifdef CSLA_OVF_EN
   ,
   output logic             o_v
`endif
);

   localparam int c_SPS = csla_sps(WIDTH, BLK, STAGES);

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_en;
   logic [STAGES-1:0] w_vin;
   logic              w_acc;
   logic              r_live;

   // Holds off acceptance until the first clock after reset release so that
   // in_ready stays low throughout reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // A stage may load when it is empty or when everything downstream of it
   // is advancing; this lets bubbles collapse.
   always_comb begin
      w_en  = '0;
      w_acc = i_out_ready;
      for (int j = STAGES - 1; j >= 0; j--) begin
         w_acc   = w_acc | ~r_vld[j];
         w_en[j] = w_acc;
      end
   end

   always_comb begin
      w_vin    = '0;
      w_vin[0] = i_in_valid & r_live;
      for (int j = 1; j < STAGES; j++) begin
         w_vin[j] = r_vld[j-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else begin
         for (int j = 0; j < STAGES; j++) begin
            if (w_en[j]) begin
               r_vld[j] <= w_vin[j];
            end
         end
      end
   end

   assign o_in_ready  = w_en[0] & r_live;
   assign o_out_valid = r_vld[STAGES-1];

   for (genvar j = 0; j < STAGES; j++) begin : g_stg
      localparam int c_LO = j * c_SPS * BLK;        // first bit resolved here
      localparam int c_HI = (j + 1) * c_SPS * BLK;  // first bit left for later

      logic [WIDTH-1:c_LO] w_a;
      logic [WIDTH-1:c_LO] w_b;
      logic                w_ci;
      logic [c_HI-1:c_LO]  w_seg_s;
      logic [c_SPS:0]      w_c;
      logic [c_HI-1:0]     w_s_nxt;
      logic                w_ld;
      logic [c_HI-1:0]     r_s;
      logic                r_c;

      // Stage inputs: raw ports for stage 0, otherwise the previous stage's
      // skewed operand bits, registered carry and already-resolved low sum.
      if (j == 0) begin : g_first
         assign w_a     = i_a;
         assign w_b     = i_b;
         assign w_ci    = i_cin;
         assign w_s_nxt = w_seg_s;
      end else begin : g_next
         assign w_a     = g_stg[j-1].g_fwd.r_a;
         assign w_b     = g_stg[j-1].g_fwd.r_b;
         assign w_ci    = g_stg[j-1].r_c;
         assign w_s_nxt = {w_seg_s, g_stg[j-1].r_s};
      end

      assign w_c[0] = w_ci;

      for (genvar k = 0; k < c_SPS; k++) begin : g_seg
         csla_seg #(
            .BLK (BLK)
         ) u_seg (
            .i_a  (w_a[c_LO + k*BLK +: BLK]),
            .i_b  (w_b[c_LO + k*BLK +: BLK]),
            .i_ci (w_c[k]),
            .o_s  (w_seg_s[c_LO + k*BLK +: BLK]),
            .o_co (w_c[k+1])
         );
      end

      // Data only moves when a valid item enters; bubbles leave it stale.
      assign w_ld = w_en[j] & w_vin[j];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s <= '0;
            r_c <= 1'b0;
         end else if (w_ld) begin
            r_s <= w_s_nxt;
            r_c <= w_c[c_SPS];
         end
      end

      // Operand bits not yet consumed travel alongside the partial sum.
      if (j < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:c_HI] r_a;
         logic [WIDTH-1:c_HI] r_b;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_ld) begin
               r_a <= w_a[WIDTH-1:c_HI];
               r_b <= w_b[WIDTH-1:c_HI];
            end
         end
      end
   end

   assign o_s    = g_stg[STAGES-1].r_s;
   assign o_cout = g_stg[STAGES-1].r_c;

`ifdef CSLA_OVF_EN
   // The sign bits are still present in the last stage's operand inputs, so
   // overflow is formed there and registered together with the sum.
   logic w_v_nxt;
   logic r_v;

   assign w_v_nxt = (g_stg[STAGES-1].w_a[WIDTH-1] == g_stg[STAGES-1].w_b[WIDTH-1]) &&
                    (g_stg[STAGES-1].w_s_nxt[WIDTH-1] != g_stg[STAGES-1].w_a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= 1'b0;
      end else if (g_stg[STAGES-1].w_ld) begin
         r_v <= w_v_nxt;
      end
   end

   assign o_v = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_csla_pipe_adder                                         |
// | Description : Self-checking bench for csla_pipe_adder (16/4/2).          |
// |               Reference: plain A+B+Cin arithmetic queued per accepted    |
// |               input, compared on every output transfer; directed tests   |
// |               pin literal results, latency, stall, bubbles and reset.    |
// |               CSLA_OVF_EN adds the o_v port and its checks.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_csla_pipe_adder;

   localparam int W   = 16;
   localparam int BLK = 4;
   localparam int ST  = 2;

   logic         clk         = 1'b0;
   logic         rst_n       = 1'b0;
   logic         i_in_valid  = 1'b0;
   logic         i_cin       = 1'b0;
   logic         i_out_ready = 1'b1;
   logic [W-1:0] i_a         = '0;
   logic [W-1:0] i_b         = '0;
   logic         o_in_ready;
   logic         o_out_valid;
   logic         o_cout;
   logic [W-1:0] o_s;
`ifdef CSLA_OVF_EN
   logic         o_v;
`endif

   csla_pipe_adder #(
      .WIDTH  (W),
      .BLK    (BLK),
      .STAGES (ST)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_cin       (i_cin),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_s         (o_s),
      .o_cout      (o_cout)
`ifdef CSLA_OVF_EN
      ,
      .o_v         (o_v)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         v;
      int           cyc;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic rnd_mode = 1'b0;

   always @(posedge clk) cyc++;

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      res_t       r;
      logic [W:0] t;
      t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      r.s   = t[W-1:0];
      r.c   = t[W];
      r.v   = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      r.cyc = 0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard / compare process.
   res_t m_e;
   res_t m_o;
   logic m_hold = 1'b0;
   logic [W-1:0] m_hs;
   logic m_hc;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_hold = 1'b0;
      end else begin
         if (m_hold) begin
            if (!o_out_valid || o_s !== m_hs || o_cout !== m_hc) begin
               n_err++;
               $display("FAIL stall_hold: got v=%b s=%h c=%b, want v=1 s=%h c=%b",
                        o_out_valid, o_s, o_cout, m_hs, m_hc);
            end
         end
         m_hold = o_out_valid && !i_out_ready;
         m_hs   = o_s;
         m_hc   = o_cout;
         if (i_in_valid && o_in_ready) begin
            exp_q.push_back(model(i_a, i_b, i_cin));
            n_vec++;
         end
         if (o_out_valid && i_out_ready) begin
            m_o.s = o_s;
            m_o.c = o_cout;
`ifdef CSLA_OVF_EN
            m_o.v = o_v;
`else
            m_o.v = 1'b0;
`endif
            m_o.cyc = cyc;
            obs_q.push_back(m_o);
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got s=%h c=%b, want no output", o_s, o_cout);
            end else begin
               m_e = exp_q.pop_front();
               if (m_o.s !== m_e.s || m_o.c !== m_e.c) begin
                  n_err++;
                  $display("FAIL result: got s=%h c=%b, want s=%h c=%b", m_o.s, m_o.c, m_e.s, m_e.c);
               end
`ifdef CSLA_OVF_EN
               if (m_o.v !== m_e.v) begin
                  n_err++;
                  $display("FAIL overflow: got v=%b, want v=%b", m_o.v, m_e.v);
               end
`endif
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int t;
      i_in_valid = 1'b1;
      i_a        = a;
      i_b        = b;
      i_cin      = c;
      t          = 0;
      @(negedge clk);
      while (!o_in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_err++;
         $display("FAIL send_timeout: got in_ready=0 for 100 cycles, want 1");
      end
      @(posedge clk);
      #1;
      i_in_valid = 1'b0;
   endtask

   task automatic idle();
      i_in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || o_out_valid) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return '0;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_mode) i_out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(o_in_ready), 0);
      chk("rst_out_valid", 32'(o_out_valid), 0);
      chk("rst_s", 32'(o_s), 0);
      chk("rst_cout", 32'(o_cout), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(o_in_ready), 1);
      chk("idle_out_valid", 32'(o_out_valid), 0);

      // 1: wrap-around with carry, latency STAGES.
      obs_q.delete();
      send(16'hFFFF, 16'h0000, 1'b1);
      @(negedge clk);
      chk("lat_early_valid", 32'(o_out_valid), 0);
      @(negedge clk);
      chk("lat_valid", 32'(o_out_valid), 1);
      chk("t1_s", 32'(o_s), 32'h0000);
      chk("t1_cout", 32'(o_cout), 1);
      @(posedge clk);
      #1;
      drain();

      // 2: back-to-back stream.
      obs_q.delete();
      send(16'h0001, 16'h0002, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h1234, 16'h4321, 1'b1);
      drain();
      chk("t2_count", 32'(obs_q.size()), 3);
      if (obs_q.size() == 3) begin
         chk("t2_s0", 32'(obs_q[0].s), 32'h0003);
         chk("t2_c0", 32'(obs_q[0].c), 0);
         chk("t2_s1", 32'(obs_q[1].s), 32'h0000);
         chk("t2_c1", 32'(obs_q[1].c), 1);
         chk("t2_s2", 32'(obs_q[2].s), 32'h5556);
         chk("t2_c2", 32'(obs_q[2].c), 0);
         chk("t2_gap01", 32'(obs_q[1].cyc - obs_q[0].cyc), 1);
         chk("t2_gap12", 32'(obs_q[2].cyc - obs_q[1].cyc), 1);
      end

      // 3: stall with a full pipe.
      obs_q.delete();
      i_out_ready = 1'b0;
      fork
         begin
            send(16'h0001, 16'h0001, 1'b0);
            send(16'h00FF, 16'h0001, 1'b0);
            send(16'hF000, 16'h1000, 1'b1);
         end
         begin
            repeat (6) @(negedge clk);
            chk("stall_in_ready", 32'(o_in_ready), 0);
            chk("stall_out_valid", 32'(o_out_valid), 1);
            chk("stall_s", 32'(o_s), 32'h0002);
            @(posedge clk);
            #1;
            i_out_ready = 1'b1;
         end
      join
      drain();
      chk("t3_count", 32'(obs_q.size()), 3);
      if (obs_q.size() == 3) begin
         chk("t3_s0", 32'(obs_q[0].s), 32'h0002);
         chk("t3_s1", 32'(obs_q[1].s), 32'h0100);
         chk("t3_s2", 32'(obs_q[2].s), 32'h0001);
         chk("t3_c2", 32'(obs_q[2].c), 1);
      end

      // 4: bubble in the input stream.
      obs_q.delete();
      send(16'h0005, 16'h0005, 1'b0);
      idle();
      send(16'h0007, 16'h0000, 1'b1);
      drain();
      chk("t4_count", 32'(obs_q.size()), 2);
      if (obs_q.size() == 2) begin
         chk("t4_s0", 32'(obs_q[0].s), 32'h000A);
         chk("t4_s1", 32'(obs_q[1].s), 32'h0008);
         chk("t4_gap", 32'(obs_q[1].cyc - obs_q[0].cyc), 2);
      end

      // 5: asynchronous reset with items in flight.
      obs_q.delete();
      send(16'h0011, 16'h0022, 1'b0);
      send(16'h0033, 16'h0044, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(o_out_valid), 0);
      chk("arst_s", 32'(o_s), 0);
      chk("arst_cout", 32'(o_cout), 0);
      chk("arst_in_ready", 32'(o_in_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_quiet", 32'(o_out_valid), 0);
      end
      chk("t5_count", 32'(obs_q.size()), 0);
      @(posedge clk);
      #1;

`ifdef CSLA_OVF_EN
      // 6: signed overflow.
      obs_q.delete();
      send(16'h7FFF, 16'h0001, 1'b0);
      send(16'h8000, 16'hFFFF, 1'b0);
      send(16'h1000, 16'h2000, 1'b0);
      drain();
      chk("t6_count", 32'(obs_q.size()), 3);
      if (obs_q.size() == 3) begin
         chk("t6_s0", 32'(obs_q[0].s), 32'h8000);
         chk("t6_v0", 32'(obs_q[0].v), 1);
         chk("t6_c0", 32'(obs_q[0].c), 0);
         chk("t6_s1", 32'(obs_q[1].s), 32'h7FFF);
         chk("t6_v1", 32'(obs_q[1].v), 1);
         chk("t6_c1", 32'(obs_q[1].c), 1);
         chk("t6_v2", 32'(obs_q[2].v), 0);
      end
`endif

      // Random traffic with random back-pressure.
      rnd_mode = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 4) == 0) idle();
         send(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      rnd_mode = 1'b0;
      @(posedge clk);
      #2;
      i_out_ready = 1'b1;
      @(posedge clk);
      #1;
      drain();
      chk("final_pending", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
